id_fwd_stage: RTL
=================

Name: id_fwd_stage

Overview:
Parametrised decode-stage front end. It holds the IF→ID pipeline register with bubble and flush control. It resolves two source operands through an N-source priority bypass network with load-use interlock. It captures bypassed operands while ID is stalled, so values retiring from WB during a stall are not lost. It sits between IF and EX and replaces the fixed EX/MEM/WB bypass muxes inside ID.

Parameters:
DATA_W, 32, operand/data width
REG_AW, 5, register address width
NUM_FWD, 3, bypass sources; index 0 = youngest (EX), then MEM, WB
PAYLOAD_W, 33, IF→ID bus width; MSB is the valid/ce bit

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall_id  in  1  hold ID register (stall[1])
stall_ex  in  1  EX stalled (stall[2])
flush  in  1  kill ID contents
if_bus  in  PAYLOAD_W  incoming IF→ID payload
raddr1, raddr2  in  REG_AW each  decoded rs/rt
use1, use2  in  1 each  instruction reads raddr1/raddr2
rf_rdata1, rf_rdata2  in  DATA_W each  regfile read data
fwd_we  in  NUM_FWD  per-source write enable
fwd_waddr  in  NUM_FWD*REG_AW  per-source write address, source k at [k*REG_AW +: REG_AW]
fwd_wdata  in  NUM_FWD*DATA_W  per-source write data
fwd_pend  in  NUM_FWD  source's data not yet available (load in flight)
id_bus  out  PAYLOAD_W  registered payload
id_valid  out  1  id_bus[PAYLOAD_W-1]
op1, op2  out  DATA_W each  resolved operands
stallreq  out  1  load-use interlock request
stall_cycles  out  32  stall statistics (see optional feature)

Behaviour:
- Clocking: one clock, clk; synchronous active-high reset, rst.
- ID register update, in priority order:
  - rst → 0.
  - flush → 0.
  - stall_id=1 and stall_ex=0 → 0 (bubble).
  - stall_id=0 → if_bus.
  - Otherwise hold.
- Reset values: id_bus=0, id_valid=0, capture regs invalid, stall_cycles=0. op1/op2/stallreq are combinational and are 0 while id_valid=0.
- Source match k for operand n:
  - use_n=1, raddr_n≠0, fwd_we[k]=1, fwd_waddr[k]=raddr_n.
  - The lowest k that matches is selected. Older matches are ignored.
- Operand select per operand, first hit wins:
  - raddr_n=0 → 0.
  - Selected source k with fwd_pend[k]=0 → fwd_wdata[k].
  - Capture reg valid → capture value.
  - Otherwise → rf_rdataN.
- Interlock: stallreq = id_valid & (selected source for op1 or op2 has fwd_pend=1). A pending selected source blocks use of capture or regfile data, because it is newer. stallreq is same-cycle combinational, with no added latency.
- Capture regs (one per operand): each cycle with id_valid=1 and stall_id=1, a non-pending selected match loads fwd_wdata[k] and sets valid.
- Capture valid is cleared on:
  - rst,
  - flush,
  - any cycle where the ID register loads if_bus or a bubble.
- Capture correctness: while ID holds, only bubbles enter EX, so a live match is always the same or newer than the captured value. Live match therefore has priority over capture.
- Simultaneous flush and stall_id: flush wins and clears capture.
- Reset mid-stall: all state cleared next edge; stallreq drops with id_valid.

Optional Feature:
Macro ID_FWD_STATS_EN.
- Defined: stall_cycles increments each clk where stallreq=1 and rst=0. It saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: no counter logic; stall_cycles tied to 0.

Test Plan:
- Reset then if_bus=33'h1_0000_1000 with stall_id=0 → next cycle id_valid=1, id_bus=33'h1_0000_1000; capture invalid, stall_cycles=0.
- raddr1=5, EX (k=0) writes r5=32'hAAAA, WB (k=2) writes r5=32'h1111 → op1=32'hAAAA; with EX we=0 → op1=32'h1111; with neither → op1=rf_rdata1.
- raddr1=0, EX writes r0=32'hFFFF → op1=0, stallreq=0.
- MEM (k=1) writes r8 with fwd_pend[1]=1, raddr2=8, use2=1 → stallreq=1. With use2=0 → stallreq=0. With EX also writing r8 non-pending → stallreq=0, op2=EX data.
- Hold ID (stall_id=1, stall_ex=1); WB writes r9=32'h1234 for one cycle, then the regfile still returns stale 32'h0 → op1 remains 32'h1234 on following cycles. Release stall → capture cleared next edge.
- Flush asserted together with stall_id and valid capture → next cycle id_valid=0, op1=op2=0. With ID_FWD_STATS_EN defined, 3 stallreq cycles give stall_cycles=3; without the macro, stall_cycles stays 0.

Source files
------------

// File: rtl/id_fwd_stage.sv
// Decode-stage front end: IF->ID register, priority bypass network, load-use interlock, stall capture.
// Optional stall statistics counter is enabled with `define ID_FWD_STATS_EN.
module id_fwd_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int NUM_FWD   = 3,
  parameter int PAYLOAD_W = 33
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_id,
  input  logic                        stall_ex,
  input  logic                        flush,
  input  logic [PAYLOAD_W-1:0]        if_bus,
  input  logic [REG_AW-1:0]           raddr1,
  input  logic [REG_AW-1:0]           raddr2,
  input  logic                        use1,
  input  logic                        use2,
  input  logic [DATA_W-1:0]           rf_rdata1,
  input  logic [DATA_W-1:0]           rf_rdata2,
  input  logic [NUM_FWD-1:0]          fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0]   fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
  input  logic [NUM_FWD-1:0]          fwd_pend,
  output logic [PAYLOAD_W-1:0]        id_bus,
  output logic                        id_valid,
  output logic [DATA_W-1:0]           op1,
  output logic [DATA_W-1:0]           op2,
  output logic                        stallreq,
  output logic [31:0]                 stall_cycles
);

  // Returns {hit, pend, data} of the youngest matching bypass source.
  function automatic logic [DATA_W+1:0] fwd_pick(
    input logic                      rd,
    input logic [REG_AW-1:0]         ra,
    input logic [NUM_FWD-1:0]        we,
    input logic [NUM_FWD*REG_AW-1:0] wa,
    input logic [NUM_FWD*DATA_W-1:0] wd,
    input logic [NUM_FWD-1:0]        pd
  );
    logic [DATA_W+1:0] res;
    res = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (rd && (ra != '0) && we[k] && (wa[k*REG_AW +: REG_AW] == ra))
        res = {1'b1, pd[k], wd[k*DATA_W +: DATA_W]};
    end
    return res;
  endfunction

  logic [PAYLOAD_W-1:0] r_id_bus_p0;
  logic                 r_cap1_vld_p0, r_cap2_vld_p0;
  logic [DATA_W-1:0]    r_cap1_p0, r_cap2_p0;
  logic                 w_hit1, w_pend1, w_hit2, w_pend2;
  logic [DATA_W-1:0]    w_fdata1, w_fdata2;
  logic                 w_vld_p0;
  logic                 w_id_load;

  assign w_vld_p0  = r_id_bus_p0[PAYLOAD_W-1];
  // ID takes a new value (payload or bubble) unless both ID and EX are stalled.
  assign w_id_load = !(stall_id && stall_ex);

  assign {w_hit1, w_pend1, w_fdata1} = fwd_pick(use1, raddr1, fwd_we, fwd_waddr, fwd_wdata, fwd_pend);
  assign {w_hit2, w_pend2, w_fdata2} = fwd_pick(use2, raddr2, fwd_we, fwd_waddr, fwd_wdata, fwd_pend);

  // Stage p0: IF->ID register
  always_ff @(posedge clk) begin
    if (rst || flush)
      r_id_bus_p0 <= '0;
    else if (stall_id && !stall_ex)
      r_id_bus_p0 <= '0;
    else if (!stall_id)
      r_id_bus_p0 <= if_bus;
  end

  always_ff @(posedge clk) begin
    if (rst || flush || w_id_load) begin
      r_cap1_vld_p0 <= 1'b0;
      r_cap2_vld_p0 <= 1'b0;
    end else if (w_vld_p0 && stall_id) begin
      if (w_hit1 && !w_pend1) r_cap1_vld_p0 <= 1'b1;
      if (w_hit2 && !w_pend2) r_cap2_vld_p0 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_vld_p0 && stall_id) begin
      if (w_hit1 && !w_pend1) r_cap1_p0 <= w_fdata1;
      if (w_hit2 && !w_pend2) r_cap2_p0 <= w_fdata2;
    end
  end

  // A pending selected source is newer than capture/regfile, so it yields 0 while the interlock holds.
  always_comb begin
    op1 = '0;
    if (w_vld_p0 && (raddr1 != '0)) begin
      if (w_hit1)             op1 = w_pend1 ? '0 : w_fdata1;
      else if (r_cap1_vld_p0) op1 = r_cap1_p0;
      else                    op1 = rf_rdata1;
    end
  end

  always_comb begin
    op2 = '0;
    if (w_vld_p0 && (raddr2 != '0)) begin
      if (w_hit2)             op2 = w_pend2 ? '0 : w_fdata2;
      else if (r_cap2_vld_p0) op2 = r_cap2_p0;
      else                    op2 = rf_rdata2;
    end
  end

  assign stallreq = w_vld_p0 && ((w_hit1 && w_pend1) || (w_hit2 && w_pend2));
  assign id_bus   = r_id_bus_p0;
  assign id_valid = w_vld_p0;

`ifdef ID_FWD_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (stallreq)
      r_stall_cycles <= sat_inc(r_stall_cycles);
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule
